// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial subtractor for one restoring-division step.
module div_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           neg
);

  // The minuend is always below twice the subtrahend, so the MSB acts as a sign bit.
  assign diff = minuend - subtrahend;
  assign neg  = diff[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN adds div_err and an early exit for divisor == 0.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic             div_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH:0]   rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] dvs_p0;
  logic [CNT_W-1:0] cnt;

  logic [2*WIDTH:0] pair_sh;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH-1:0] shift_quo;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_quo;
  logic             last_iter;

  // Iteration datapath: shift {rem, quo} left, trial subtract, restore on borrow
  assign pair_sh   = {rem_p0, quo_p0} << 1;
  assign shift_rem = pair_sh[2*WIDTH:WIDTH];
  assign shift_quo = pair_sh[WIDTH-1:0];

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .minuend   (shift_rem),
    .subtrahend({1'b0, dvs_p0}),
    .diff      (trial),
    .neg       (trial_neg)
  );

  assign next_rem  = trial_neg ? shift_rem : trial;
  assign next_quo  = shift_quo | {{(WIDTH-1){1'b0}}, ~trial_neg};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
`ifdef DIV_ZERO_CHECK_EN
      div_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            quo_p0 <= dividend;
            rem_p0 <= '0;
            dvs_p0 <= divisor;
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            div_err <= (divisor == '0);
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          rem_p0 <= next_rem;
          quo_p0 <= next_quo;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= next_quo;
            remainder <= next_rem[WIDTH-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: arithmetic reference model plus directed literals.
module tb_restoring_divider;

  localparam int W = 4;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done;
`ifdef DIV_ZERO_CHECK_EN
  logic         div_err;
`endif

  restoring_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done)
`ifdef DIV_ZERO_CHECK_EN
    ,
    .div_err  (div_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: operation timing in edge numbers, results from plain arithmetic
  int acc_at = -1, done_at = -1, free_at = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_q = '0; m_r = '0; m_err = 1'b0;
      acc_at = -1; done_at = -1; free_at = cyc + 1;
    end else if (start && cyc >= free_at) begin
      if (divisor != 0) begin
        p_q = dividend / divisor;
        p_r = dividend % divisor;
      end else begin
        p_q = {W{1'b1}};
        p_r = dividend;
      end
      m_err   = ZCHK && (divisor == 0);
      acc_at  = cyc;
      done_at = cyc + ((ZCHK && divisor == 0) ? 0 : W);
      free_at = done_at + 2;
    end
    if (!rst && cyc == done_at) begin
      m_q = p_q;
      m_r = p_r;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("done", done, cyc == done_at);
      check("busy", busy, acc_at >= 0 && cyc >= acc_at && cyc <= done_at);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
`ifdef DIV_ZERO_CHECK_EN
      check("div_err", div_err, m_err);
`endif
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                       output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    int s;
    bit ok;
    @(posedge clk); #1;
    s = cyc; start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor = W'($urandom);
      end
    end
    start = 1'b0;
    check("done_seen", ok, 1);
    q = quotient; r = remainder; lat = cyc - s;
  endtask

  initial begin
    logic [W-1:0] q, r, a, b;
    int lat, nd, tmp, j;
    int dcyc[3];
    int perm[256];

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    do_op(4'd13, 4'd3, 1'b0, q, r, lat);
    check("13/3_q", q, 4); check("13/3_r", r, 1); check("13/3_lat", lat, 5);
    do_op(4'd15, 4'd15, 1'b0, q, r, lat);
    check("15/15_q", q, 1); check("15/15_r", r, 0);
    do_op(4'd7, 4'd9, 1'b0, q, r, lat);
    check("7/9_q", q, 0); check("7/9_r", r, 7);
    do_op(4'd0, 4'd5, 1'b0, q, r, lat);
    check("0/5_q", q, 0); check("0/5_r", r, 0);
    do_op(4'd9, 4'd0, 1'b0, q, r, lat);
    check("9/0_q", q, 15); check("9/0_r", r, 9);
    check("9/0_lat", lat, ZCHK ? 1 : 5);
`ifdef DIV_ZERO_CHECK_EN
    check("9/0_err", div_err, 1);
`endif

    // start held high: operations re-accepted only from IDLE
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    nd = 0;
    for (int i = 0; i < 40 && nd < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc[nd] = cyc;
        check("b2b_q", quotient, 4);
        check("b2b_r", remainder, 1);
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_count", nd, 3);
    check("b2b_gap1", dcyc[1] - dcyc[0], W + 2);
    check("b2b_gap2", dcyc[2] - dcyc[1], W + 2);

    // reset at E2 of 13/3
    repeat (2) @(posedge clk);
    #1 start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    nd = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);
    do_op(4'd6, 4'd4, 1'b0, q, r, lat);
    check("6/4_q", q, 1); check("6/4_r", r, 2);

    // all operand pairs in shuffled order, start toggled randomly while busy
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      tmp = perm[i];
      a = W'(tmp >> 4);
      b = W'(tmp & 15);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      do_op(a, b, 1'b1, q, r, lat);
      if (b != 0) begin
        check("sweep_q", q, a / b);
        check("sweep_r", r, a % b);
      end else begin
        check("sweep_q0", q, 15);
        check("sweep_r0", r, a);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
